// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg : shared geometry, FSM encoding and address-field helpers
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

   localparam int DC_NUM_LINES  = 32;
   localparam int DC_LINE_WORDS = 8;

   localparam int IDX_W  = $clog2(DC_NUM_LINES);
   localparam int WSEL_W = $clog2(DC_LINE_WORDS);
   localparam int OFF_W  = WSEL_W + 2;
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int LINE_W = 32 * DC_LINE_WORDS;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2
   } state_e;

   function automatic logic [WSEL_W-1:0] addr_wsel(input logic [31:0] a);
      return a[2 +: WSEL_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
      return a[OFF_W+IDX_W +: TAG_W];
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_store.sv
// ---------------------------------------------------------------------------
// dcache_store : valid/dirty/tag/data arrays, async read, sync word/line write
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_store
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = DC_NUM_LINES
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_line_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [WSEL_W-1:0] wr_wsel_i,
   input  logic [31:0]       wr_data_i,
   input  logic              fill_en_i,
   input  logic [IDX_W-1:0]  fill_idx_i,
   input  logic [TAG_W-1:0]  fill_tag_i,
   input  logic [LINE_W-1:0] fill_line_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en_i) begin
         valid_q[fill_idx_i] <= 1'b1;
         dirty_q[fill_idx_i] <= 1'b0;
      end else if (wr_en_i) begin
         dirty_q[wr_idx_i] <= 1'b1;
      end
   end

   // Fill (REFILL only) and word write (IDLE hit only) are never concurrent.
   always_ff @(posedge clk_i) begin
      if (fill_en_i) begin
         tag_q[fill_idx_i]  <= fill_tag_i;
         data_q[fill_idx_i] <= fill_line_i;
      end else if (wr_en_i) begin
         data_q[wr_idx_i][32*wr_wsel_i +: 32] <= wr_data_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl : direct-mapped write-back/write-allocate D-cache controller.
// Option DCACHE_STATS_EN adds saturating hit/miss counters. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES  = DC_NUM_LINES,
   parameter int LINE_WORDS = DC_LINE_WORDS
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cpu_req_i,
   input  logic                     cpu_we_i,
   input  logic [31:0]              cpu_addr_i,
   input  logic [31:0]              cpu_wdata_i,
   output logic [31:0]              cpu_rdata_o,
   output logic                     cpu_stall_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [31:0]              mem_addr_o,
   output logic [32*LINE_WORDS-1:0] mem_wdata_o,
   input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
   input  logic                     mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]              hit_cnt_o,
   output logic [31:0]              miss_cnt_o
`endif
);

   state_e            state_q, state_d;
   logic [TAG_W-1:0]  req_tag_q, req_tag_d;
   logic [IDX_W-1:0]  req_idx_q, req_idx_d;

   logic [IDX_W-1:0]  cpu_idx, rd_idx;
   logic [TAG_W-1:0]  cpu_tag, rd_tag;
   logic [WSEL_W-1:0] cpu_wsel;
   logic              rd_valid, rd_dirty, hit, fill_en;
   logic [LINE_W-1:0] rd_line;

   assign cpu_idx  = addr_idx(cpu_addr_i);
   assign cpu_tag  = addr_tag(cpu_addr_i);
   assign cpu_wsel = addr_wsel(cpu_addr_i);

   // Outside IDLE the store is addressed by the latched miss, so the victim
   // stays stable even if the CPU lets go of its request.
   assign rd_idx  = (state_q == ST_IDLE) ? cpu_idx : req_idx_q;
   assign hit     = (state_q == ST_IDLE) & cpu_req_i & rd_valid & (rd_tag == cpu_tag);
   assign fill_en = (state_q == ST_REFILL) & mem_ack_i;

   dcache_store #(
      .NUM_LINES (NUM_LINES)
   ) u_store (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_idx_i    (rd_idx),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_line_o   (rd_line),
      .wr_en_i     (hit & cpu_we_i),
      .wr_idx_i    (cpu_idx),
      .wr_wsel_i   (cpu_wsel),
      .wr_data_i   (cpu_wdata_i),
      .fill_en_i   (fill_en),
      .fill_idx_i  (req_idx_q),
      .fill_tag_i  (req_tag_q),
      .fill_line_i (mem_rdata_i)
   );

   always_comb begin
      state_d   = state_q;
      req_tag_d = req_tag_q;
      req_idx_d = req_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req_i & ~hit) begin
               req_tag_d = cpu_tag;
               req_idx_d = cpu_idx;
               state_d   = (rd_valid & rd_dirty) ? ST_WRITEBACK : ST_REFILL;
            end
         end
         ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
         ST_REFILL:    if (mem_ack_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_IDLE;
         req_tag_q <= '0;
         req_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         req_tag_q <= req_tag_d;
         req_idx_q <= req_idx_d;
      end
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         ST_WRITEBACK: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = line_addr(rd_tag, req_idx_q);
            mem_wdata_o = rd_line;
         end
         ST_REFILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = line_addr(req_tag_q, req_idx_q);
         end
         default: ;
      endcase
   end

   assign cpu_rdata_o = hit ? rd_line[32*cpu_wsel +: 32] : 32'd0;
   assign cpu_stall_o = rst_i & ((state_q == ST_IDLE) ? (cpu_req_i & ~hit) : 1'b1);

`ifdef DCACHE_STATS_EN
   logic        refilled_q;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // The cycle after a fill is the re-lookup of a miss, never a fresh hit.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         refilled_q <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         refilled_q <= fill_en;
         if (hit & ~refilled_q & (hit_cnt_q != '1))
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if ((state_q == ST_IDLE) & cpu_req_i & ~hit & (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl : scoreboard bench, flat-memory reference model + mem responder
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              cpu_req_i = 1'b0;
   logic              cpu_we_i = 1'b0;
   logic [31:0]       cpu_addr_i = '0;
   logic [31:0]       cpu_wdata_i = '0;
   logic [31:0]       cpu_rdata_o;
   logic              cpu_stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic [LINE_W-1:0] mem_rdata_i = '0;
   logic              mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

   dcache_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit                we;
      logic [31:0]       addr;
      logic [LINE_W-1:0] line;
   } mexp_t;

   int n_cmp = 0;
   int n_bad = 0;
   int fixed_lat = 0;  // <0 selects random ack latency 0..3
   int exp_hits = 0;
   int exp_misses = 0;

   logic [31:0]       exp_q[$];
   mexp_t             mem_exp_q[$];
   logic [LINE_W-1:0] bmem [int unsigned];     // backing memory, by line address
   logic [31:0]       ref_mem [int unsigned];  // words the CPU has stored, by word address
   bit                m_valid [DC_NUM_LINES];
   bit                m_dirty [DC_NUM_LINES];
   logic [TAG_W-1:0]  m_tag   [DC_NUM_LINES];

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] init_line(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      for (int w = 0; w < DC_LINE_WORDS; w++)
         l[w*32 +: 32] = (a ^ 32'h5EED_0000) + 32'(w) * 32'h0101_0101;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] bline(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return init_line(a);
   endfunction

   // What a perfect memory would return for a word: last store, else backing memory.
   function automatic logic [31:0] ref_word(input logic [31:0] wa);
      logic [LINE_W-1:0] l;
      logic [31:0]       la;
      if (ref_mem.exists(wa)) return ref_mem[wa];
      la = wa & ~32'(LINE_W/8 - 1);
      l  = bline(la);
      return l[32*((wa - la) >> 2) +: 32];
   endfunction

   function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] la);
      logic [LINE_W-1:0] l;
      for (int w = 0; w < DC_LINE_WORDS; w++)
         l[w*32 +: 32] = ref_word(la + 32'(4*w));
      return l;
   endfunction

   task automatic model_issue(input bit we, input logic [31:0] a, input logic [31:0] d);
      int unsigned      idx;
      logic [TAG_W-1:0] tag;
      logic [31:0]      wa;
      idx = (a >> OFF_W) % DC_NUM_LINES;
      tag = a >> (OFF_W + IDX_W);
      wa  = a & ~32'd3;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         exp_hits++;
      end else begin
         exp_misses++;
         if (m_valid[idx] && m_dirty[idx])
            mem_exp_q.push_back('{1'b1, {m_tag[idx], IDX_W'(idx), {OFF_W{1'b0}}},
                                  ref_line({m_tag[idx], IDX_W'(idx), {OFF_W{1'b0}}})});
         mem_exp_q.push_back('{1'b0, {tag, IDX_W'(idx), {OFF_W{1'b0}}}, '0});
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tag;
      end
      exp_q.push_back(ref_word(wa));
      if (we) begin
         ref_mem[wa]  = d;
         m_dirty[idx] = 1'b1;
      end
   endtask

   // Call at posedge+1; returns at posedge+1 after the access is accepted.
   task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, output int stalls);
      model_issue(we, a, d);
      cpu_req_i   = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = a;
      cpu_wdata_i = d;
      stalls      = 0;
      forever begin
         @(negedge clk_i);
         if (!cpu_stall_o) break;
         stalls++;
         if (stalls > 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", a, stalls);
            break;
         end
      end
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;
   endtask

   // Monitor: every accepted access is compared against the scoreboard head.
   always @(negedge clk_i) begin
      if (rst_i && cpu_req_i && !cpu_stall_o) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdata_unexpected: got %0h with empty scoreboard", cpu_rdata_o);
         end else begin
            chk("cpu_rdata", LINE_W'(cpu_rdata_o), LINE_W'(exp_q.pop_front()));
         end
      end
   end

   // Memory responder: checks each transaction against the expected queue.
   initial begin
      bit          busy = 1'b0;
      int          cnt = 0;
      bit          t_we = 1'b0;
      logic [31:0] t_addr = '0;
      mexp_t       e;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            busy = 1'b0;
            continue;
         end
         if (mem_req_o && !busy) begin
            busy   = 1'b1;
            cnt    = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
            t_we   = mem_we_o;
            t_addr = mem_addr_o;
            if (mem_exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL mem_unexpected: we %0b addr %0h", t_we, t_addr);
            end else begin
               e = mem_exp_q.pop_front();
               chk("mem_we", LINE_W'(t_we), LINE_W'(e.we));
               chk("mem_addr", LINE_W'(t_addr), LINE_W'(e.addr));
               if (e.we) chk("wb_line", mem_wdata_o, e.line);
            end
         end
         if (busy) begin
            if (cnt == 0) begin
               chk("mem_stable", LINE_W'({mem_req_o, mem_we_o, mem_addr_o}),
                   LINE_W'({1'b1, t_we, t_addr}));
               if (t_we) bmem[t_addr] = mem_wdata_o;
               else      mem_rdata_i = bline(t_addr);
               mem_ack_i = 1'b1;
               @(posedge clk_i);
               #1;
               mem_ack_i = 1'b0;
               busy = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      int                st;
      logic [LINE_W-1:0] l;
      l = init_line(32'h40);
      l[31:0] = 32'hDEAD_BEEF;
      bmem[32'h40] = l;

      #1;
      chk("rst_stall", LINE_W'(cpu_stall_o), '0);
      chk("rst_mem_req", LINE_W'({mem_req_o, mem_we_o, mem_addr_o}), '0);
      chk("rst_mem_wdata", mem_wdata_o, '0);
      chk("rst_rdata", LINE_W'(cpu_rdata_o), '0);
`ifdef DCACHE_STATS_EN
      chk("rst_counters", LINE_W'({hit_cnt_o, miss_cnt_o}), '0);
`endif
      repeat (2) @(negedge clk_i);
      #2 rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Cold load miss, ack in the 3rd request cycle.
      fixed_lat = 2;
      access(1'b0, 32'h40, 32'h0, st);
      chk("cold_miss_stalls", LINE_W'(st), LINE_W'(4));
      fixed_lat = 0;
      access(1'b1, 32'h44, 32'h1234_5678, st);
      chk("store_hit_stalls", LINE_W'(st), '0);
      access(1'b0, 32'h44, 32'h0, st);
      chk("load_hit_stalls", LINE_W'(st), '0);
      // Same index, new tag: dirty writeback then refill, both acked at once.
      access(1'b0, 32'h440, 32'h0, st);
      chk("dirty_miss_stalls", LINE_W'(st), LINE_W'(3));
      chk("wb_word1", LINE_W'(bmem[32'h40][63:32]), LINE_W'(32'h1234_5678));
`ifdef DCACHE_STATS_EN
      #1;
      chk("stats_hits", LINE_W'(hit_cnt_o), LINE_W'(2));
      chk("stats_misses", LINE_W'(miss_cnt_o), LINE_W'(2));
      @(posedge clk_i);
      #1;
`endif
      // Write miss allocate.
      access(1'b1, 32'h0000_2084, 32'hA5A5_A5A5, st);
      chk("write_alloc_stalls", LINE_W'(st), LINE_W'(2));
      access(1'b0, 32'h0000_2084, 32'h0, st);
      chk("write_alloc_readback_stalls", LINE_W'(st), '0);

      // Reset during a long refill.
      fixed_lat = 8;
      model_issue(1'b0, 32'h100, 32'h0);
      cpu_req_i  = 1'b1;
      cpu_addr_i = 32'h100;
      for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk_i);
      @(negedge clk_i);
      #2;
      rst_i     = 1'b0;
      cpu_req_i = 1'b0;
      #1;
      chk("rst_mid_mem_req", LINE_W'(mem_req_o), '0);
      chk("rst_mid_stall", LINE_W'(cpu_stall_o), '0);
      foreach (m_valid[i]) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      ref_mem.delete();  // dirty data is discarded by reset
      exp_q.delete();
      mem_exp_q.delete();
      exp_hits   = 0;
      exp_misses = 0;
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      fixed_lat = 0;
      access(1'b0, 32'h100, 32'h0, st);
      chk("post_rst_miss_stalls", LINE_W'(st), LINE_W'(2));
      access(1'b0, 32'h0000_2084, 32'h0, st);

      // Randomised traffic over a few conflicting lines.
      fixed_lat = -1;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << (OFF_W + IDX_W)) |
             (32'($urandom_range(0, 3)) << OFF_W) |
             (32'($urandom_range(0, DC_LINE_WORDS - 1)) << 2);
         access(1'($urandom_range(0, 1)), a, $urandom, st);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i);
            #1;
         end
      end

      repeat (3) @(negedge clk_i);
      chk("scoreboard_drained", LINE_W'(exp_q.size()), '0);
      chk("mem_exp_drained", LINE_W'(mem_exp_q.size()), '0);
`ifdef DCACHE_STATS_EN
      chk("stats_hits_final", LINE_W'(hit_cnt_o), LINE_W'(exp_hits));
      chk("stats_misses_final", LINE_W'(miss_cnt_o), LINE_W'(exp_misses));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller. It sits between the pipelined CPU's MEM stage and a slow line-wide data memory. On the CPU side it answers word load/store requests and holds the pipeline via a stall. On the memory side it acts as initiator for line writebacks and refills using a req/ack handshake.

## Interface
- `NUM_LINES`, 32: number of cache lines (power of 2). Index width IDX_W = log2(NUM_LINES).
- `LINE_WORDS`, 8: 32-bit words per line (power of 2). Line width LINE_W = 32*LINE_WORDS.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `cpu_req_i` input 1: CPU memory access valid (load or store).
- `cpu_we_i` input 1: 1 = store, 0 = load.
- `cpu_addr_i` input 32: byte address. Bits [1:0] are ignored (word accesses only).
- `cpu_wdata_i` input 32: store data.
- `cpu_rdata_o` output 32: load data, valid in the cycle `cpu_stall_o` is 0.
- `cpu_stall_o` output 1: holds the pipeline.
- `mem_req_o` output 1: memory transaction request.
- `mem_we_o` output 1: 1 = line writeback, 0 = line refill.
- `mem_addr_o` output 32: line-aligned byte address (low offset bits zero).
- `mem_wdata_o` output LINE_W: writeback line.
- `mem_rdata_i` input LINE_W: refill line, sampled in the `mem_ack_i` cycle.
- `mem_ack_i` input 1: one-cycle completion pulse.
- `hit_cnt_o` output 32: only with DCACHE_STATS_EN.
- `miss_cnt_o` output 32: only with DCACHE_STATS_EN.

## Operation
- **Address split:** offset = [OFF_W-1:0], where OFF_W = log2(LINE_WORDS)+2. Word select = [OFF_W-1:2]. Index = next IDX_W bits. Tag = remaining upper bits.
- **Per-line state:** valid, dirty, tag, data. Reset clears all valid and dirty bits. Data and tag contents are not reset.
- **Hit:** valid[idx] & tag match & `cpu_req_i`.
- **FSM states:** IDLE, WRITEBACK, REFILL.
- **IDLE behaviour:**
  - Hit load: `cpu_rdata_o` = selected word, stall 0.
  - Hit store: on the clock edge, write the word into the line and set dirty=1. Stall 0.
  - Miss with victim dirty: assert stall, go to WRITEBACK.
  - Miss with victim clean or invalid: assert stall, go to REFILL.
- **WRITEBACK:** `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, idx, 0}, `mem_wdata_o`=victim line. On `mem_ack_i`, go to REFILL.
- **REFILL:** `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={req tag, idx, 0}. On `mem_ack_i`, write `mem_rdata_i` into the line, set valid=1, dirty=0, and return to IDLE. The re-lookup in IDLE then hits, and a store merges its word there.
- **cpu_stall_o:** `cpu_req_i & ~hit` in IDLE. Constant 1 in WRITEBACK and REFILL. Forced 0 while in reset.
- **Memory outputs:** `mem_addr_o`, `mem_wdata_o`, and `mem_we_o` stay stable while `mem_req_o` is high. `mem_req_o` is never dropped before ack.
- **CPU-side rule:** the CPU holds `cpu_req_i`, `cpu_we_i`, `cpu_addr_i`, and `cpu_wdata_i` stable while stalled. If it drops them, the FSM still completes the transaction and returns to IDLE.
- **Stray acks:** `mem_ack_i` in IDLE is ignored.
- **No request:** `cpu_rdata_o` = 0 when there is no hit.

## Timing
- **Reset values:** `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `cpu_rdata_o`=0, `cpu_stall_o`=0, state IDLE, counters 0.
- **Hit:** zero added latency. Load data is combinational from the line store in the request cycle. Store data is committed at that cycle's edge.
- **Clean miss:** stall in the request cycle (C0). REFILL runs from C1 until ack at Ca. IDLE hit in Ca+1, where stall drops.
- **Dirty miss:** as a clean miss, but with the WRITEBACK phase ahead of REFILL. The two phases run back-to-back with no idle cycle between them.
- **Back-to-back memory acks:** with ack latency of 1 cycle (ack in the first req cycle), a clean miss costs 2 stall cycles.
- **Reset mid-transaction:** immediate return to IDLE, `mem_req_o` drops asynchronously, and the transaction is abandoned. All lines become invalid, so dirty data is lost by design.

## Configuration
- **DCACHE_STATS_EN defined:**
  - `hit_cnt_o` increments once per access that hits in IDLE without having missed. A refill re-lookup counts as a miss, not a hit.
  - `miss_cnt_o` increments once per IDLE miss detection.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- **DCACHE_STATS_EN undefined:** counters and both ports are absent. All other behaviour is identical.

## Structure
- **Shared package `dcache_pkg`:**
  - state enum (IDLE, WRITEBACK, REFILL);
  - localparams OFF_W, IDX_W, TAG_W, LINE_W;
  - address-field extraction functions.
- **Sub-module `dcache_store`:** holds the valid/dirty/tag/data arrays. It has asynchronous read, a synchronous word write with dirty set, a synchronous line fill with valid set and dirty cleared, and asynchronous clear of valid/dirty.
- **`dcache_ctrl`:** contains the FSM, hit logic, and memory-side muxing.

## Test plan
- **Cold load miss:** after reset, load 0x0000_0040 with memory returning a line whose word0 = 0xDEAD_BEEF and ack on the 3rd req cycle. Expect stall for 4 cycles, then `cpu_rdata_o` = 0xDEAD_BEEF with stall 0.
- **Store hit then load:** store 0x1234_5678 to 0x44 (line resident). Expect no stall, dirty set, and a following load of 0x44 returning 0x1234_5678 with zero latency.
- **Dirty eviction:** after the store above, load 0x0000_0440 (same index, new tag). Expect a writeback at `mem_addr_o` 0x40 whose line word1 = 0x1234_5678, then a refill at 0x440, then a hit.
- **Write miss allocate:** store 0xA5A5_A5A5 to an invalid line. Expect a refill, then the merged word, and a following load returning 0xA5A5_A5A5.
- **Reset mid-refill:** pulse `rst_i` low during REFILL. Expect `mem_req_o` = 0 immediately and stall 0. The next access to the same address misses again.
- **Stats (DCACHE_STATS_EN):** run the first three scenarios. Expect `miss_cnt_o` = 2 and `hit_cnt_o` = 2.
